// File: rtl/owm_arb.sv
// ----------------------------------------------------------------------------
// owm_arb -- two-requester ownership arbiter in front of a 1-wire bit engine.
//
// A requester is granted ownership of the bus and keeps it across several
// bit cycles (reset/presence, write-0, write-1/read) until it sends an
// end-of-transaction command or stays silent for TMO cycles. Commands of the
// owner are forwarded one at a time to the bit engine. The engine's sampled
// bit is returned to the owner with a one-cycle completion pulse.
//
// Every output is driven straight from a flop. The next value of each flop
// is computed in one combinational next-state block.
// ----------------------------------------------------------------------------
module owm_arb #(
    parameter int unsigned TMO = 1024
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req_valid,
    input  logic [3:0] req_cmd,
    output logic [1:0] req_ready,
    output logic [1:0] rsp_done,
    output logic       rsp_bit,
    output logic       eng_valid,
    output logic [1:0] eng_cmd,
    input  logic       eng_ready,
    input  logic       eng_done,
    input  logic       eng_bit,
    output logic [1:0] owner,
    output logic       tmo
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWNED = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    // Command encoding; the first three values go to the engine unchanged.
    localparam logic [1:0] CMD_END = 2'd3;

    // The idle counter counts 0 .. TMO-1; reaching the last value revokes.
    localparam logic [15:0] TMO_LAST = 16'(TMO - 32'd1);

    // Round-robin tie break: on a tie the requester that did not own the
    // bus last time wins. last_r holds the index of the previous owner.
    function automatic logic [1:0] pick_grant(input logic [1:0] valid,
                                              input logic       last);
        logic [1:0] grant;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
        return grant;
    endfunction

    // Extract the two-bit command of requester idx from the packed bus.
    function automatic logic [1:0] sel_cmd(input logic [3:0] cmd,
                                           input logic       idx);
        logic [1:0] sel;
        case (idx)
            1'b0:    sel = cmd[1:0];
            1'b1:    sel = cmd[3:2];
            default: sel = 2'b00;
        endcase
        return sel;
    endfunction

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    state_t      state_r;
    logic [1:0]  owner_r;
    logic        last_r;
    logic [15:0] cnt_r;
    logic        eng_valid_r;
    logic [1:0]  eng_cmd_r;
    logic [1:0]  req_ready_r;
    logic [1:0]  rsp_done_r;
    logic        rsp_bit_r;
    logic        tmo_r;

    // Next-state values
    state_t      state_s;
    logic [1:0]  owner_s;
    logic        last_s;
    logic [15:0] cnt_s;
    logic        eng_valid_s;
    logic [1:0]  eng_cmd_s;
    logic [1:0]  req_ready_s;
    logic [1:0]  rsp_done_s;
    logic        rsp_bit_s;
    logic        tmo_s;

    // Decoded view of the current owner and its command
    logic        owner_idx_s;
    logic        own_valid_s;
    logic [1:0]  own_cmd_s;
    logic [1:0]  grant_s;
    logic        cnt_last_s;

    // Decode owner index, owner's command and the candidate grant.
    always_comb begin
        owner_idx_s = owner_r[1];
        own_valid_s = req_valid[owner_idx_s];
        own_cmd_s   = sel_cmd(req_cmd, owner_idx_s);
        grant_s     = pick_grant(req_valid, last_r);
        cnt_last_s  = (cnt_r == TMO_LAST);
    end

    // Next-state and next-output logic of the arbitration FSM.
    always_comb begin
        state_s     = state_r;
        owner_s     = owner_r;
        last_s      = last_r;
        cnt_s       = cnt_r;
        eng_valid_s = eng_valid_r;
        eng_cmd_s   = eng_cmd_r;
        rsp_done_s  = 2'b00;
        rsp_bit_s   = rsp_bit_r;
        tmo_s       = 1'b0;

        case (state_r)
            ST_IDLE: begin
                // Grant only; the owner's first command is taken in OWNED.
                if (grant_s != 2'b00) begin
                    owner_s = grant_s;
                    cnt_s   = 16'd0;
                    state_s = ST_OWNED;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_OWNED: begin
                // An accept beats a timeout landing on the same cycle.
                if (own_valid_s) begin
                    if (own_cmd_s == CMD_END) begin
                        rsp_done_s = owner_r;
                        rsp_bit_s  = 1'b0;
                        last_s     = owner_idx_s;
                        owner_s    = 2'b00;
                        cnt_s      = 16'd0;
                        state_s    = ST_IDLE;
                    end else begin
                        eng_cmd_s   = own_cmd_s;
                        eng_valid_s = 1'b1;
                        cnt_s       = 16'd0;
                        state_s     = ST_ISSUE;
                    end
                end else if (cnt_last_s) begin
                    tmo_s   = 1'b1;
                    last_s  = owner_idx_s;
                    owner_s = 2'b00;
                    cnt_s   = 16'd0;
                    state_s = ST_IDLE;
                end else begin
                    cnt_s   = cnt_r + 16'd1;
                    state_s = ST_OWNED;
                end
            end

            ST_ISSUE: begin
                // Request stays up, command frozen, until the engine takes it.
                if (eng_ready) begin
                    eng_valid_s = 1'b0;
                    state_s     = ST_WAIT;
                end else begin
                    eng_valid_s = 1'b1;
                    state_s     = ST_ISSUE;
                end
            end

            ST_WAIT: begin
                // Only here is eng_done meaningful; elsewhere it is dropped.
                if (eng_done) begin
                    rsp_bit_s  = eng_bit;
                    rsp_done_s = owner_r;
                    cnt_s      = 16'd0;
                    state_s    = ST_OWNED;
                end else begin
                    state_s = ST_WAIT;
                end
            end

            default: begin
                state_s     = ST_IDLE;
                owner_s     = 2'b00;
                eng_valid_s = 1'b0;
                cnt_s       = 16'd0;
            end
        endcase

        // Registered ready: follows the owner whenever the next state is OWNED.
        if (state_s == ST_OWNED) begin
            req_ready_s = owner_s;
        end else begin
            req_ready_s = 2'b00;
        end
    end

    // State/output register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            owner_r     <= 2'b00;
            last_r      <= 1'b1;
            cnt_r       <= 16'd0;
            eng_valid_r <= 1'b0;
            eng_cmd_r   <= 2'b00;
            req_ready_r <= 2'b00;
            rsp_done_r  <= 2'b00;
            rsp_bit_r   <= 1'b0;
            tmo_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            owner_r     <= owner_s;
            last_r      <= last_s;
            cnt_r       <= cnt_s;
            eng_valid_r <= eng_valid_s;
            eng_cmd_r   <= eng_cmd_s;
            req_ready_r <= req_ready_s;
            rsp_done_r  <= rsp_done_s;
            rsp_bit_r   <= rsp_bit_s;
            tmo_r       <= tmo_s;
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_done  = rsp_done_r;
    assign rsp_bit   = rsp_bit_r;
    assign eng_valid = eng_valid_r;
    assign eng_cmd   = eng_cmd_r;
    assign owner     = owner_r;
    assign tmo       = tmo_r;

endmodule

// File: tb/tb_owm_arb.sv
// ----------------------------------------------------------------------------
// tb_owm_arb -- self-checking bench for owm_arb (TMO = 8).
// Completion and timeout events are predicted into a scoreboard queue when
// the stimulus is driven; a negedge monitor pops and compares each event.
// Cycle-exact state checks are made #1 after the active edge.
// ----------------------------------------------------------------------------
module tb_owm_arb;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] req_valid;
    logic [3:0] req_cmd;
    logic [1:0] req_ready;
    logic [1:0] rsp_done;
    logic       rsp_bit;
    logic       eng_valid;
    logic [1:0] eng_cmd;
    logic       eng_ready;
    logic       eng_done;
    logic       eng_bit;
    logic [1:0] owner;
    logic       tmo;

    int         n_chk  = 0;
    int         n_fail = 0;
    int         hi_cnt;
    logic [3:0] sb_q[$];
    logic [3:0] sb_exp;

    always #5 clk = ~clk;

    owm_arb #(.TMO(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_cmd   (req_cmd),
        .req_ready (req_ready),
        .rsp_done  (rsp_done),
        .rsp_bit   (rsp_bit),
        .eng_valid (eng_valid),
        .eng_cmd   (eng_cmd),
        .eng_ready (eng_ready),
        .eng_done  (eng_done),
        .eng_bit   (eng_bit),
        .owner     (owner),
        .tmo       (tmo)
    );

    // Single comparison point: counts and reports.
    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected event {tmo, rsp_done[1:0], rsp_bit}.
    task automatic push_ev(input logic t, input logic [1:0] d, input logic b);
        sb_q.push_back({t, d, b});
    endtask

    task automatic check_rst(input string tag);
        check_val({tag, "_owner"},     owner,     32'd0);
        check_val({tag, "_req_ready"}, req_ready, 32'd0);
        check_val({tag, "_eng_valid"}, eng_valid, 32'd0);
        check_val({tag, "_eng_cmd"},   eng_cmd,   32'd0);
        check_val({tag, "_rsp_done"},  rsp_done,  32'd0);
        check_val({tag, "_rsp_bit"},   rsp_bit,   32'd0);
        check_val({tag, "_tmo"},       tmo,       32'd0);
    endtask

    // Scoreboard monitor: every completion/timeout pulse must be predicted.
    always @(negedge clk) begin
        if (rsp_done != 2'b00 || tmo) begin
            if (sb_q.size() == 0) begin
                check_val("sb_unexpected", {28'd0, tmo, rsp_done, rsp_bit}, 32'd0);
            end else begin
                sb_exp = sb_q.pop_front();
                check_val("sb_event", {28'd0, tmo, rsp_done, rsp_bit}, {28'd0, sb_exp});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        req_valid = 2'b00;
        req_cmd   = 4'b0000;
        eng_ready = 1'b0;
        eng_done  = 1'b0;
        eng_bit   = 1'b0;
        repeat (3) tick();
        check_rst("rst0");
        reset_n = 1'b1;

        // Tie after reset goes to r0; r0 ends; pending r1 granted next.
        req_valid = 2'b11; req_cmd = 4'b1111; push_ev(1'b0, 2'b01, 1'b0);
        tick();
        check_val("tie_owner", owner, 32'h1);
        check_val("tie_ready", req_ready, 32'h1);
        tick();
        check_val("end_r0_owner", owner, 32'h0);
        check_val("end_r0_ready", req_ready, 32'h0);
        req_valid = 2'b10; push_ev(1'b0, 2'b10, 1'b0);
        tick();
        check_val("pend_r1_owner", owner, 32'h2);
        check_val("pend_r1_ready", req_ready, 32'h2);
        tick();
        check_val("end_r1_owner", owner, 32'h0);
        req_valid = 2'b00; req_cmd = 4'b0000;

        // r0 reset/presence cycle, engine accepts late, returns bit 1.
        req_valid = 2'b01; req_cmd = 4'b0000; push_ev(1'b0, 2'b01, 1'b1);
        tick();
        check_val("p_grant", owner, 32'h1);
        tick();
        check_val("p_eng_valid", eng_valid, 32'h1);
        check_val("p_eng_cmd", eng_cmd, 32'h0);
        check_val("p_ready_issue", req_ready, 32'h0);
        req_valid = 2'b00;
        hi_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (eng_valid) hi_cnt++;
            eng_ready = (i == 3) ? 1'b1 : 1'b0;
            tick();
            eng_ready = 1'b0;
        end
        check_val("p_eng_hi_cycles", hi_cnt, 32'd4);
        check_val("p_eng_valid_low", eng_valid, 32'h0);
        eng_done = 1'b1; eng_bit = 1'b1;
        tick();
        eng_done = 1'b0; eng_bit = 1'b0;
        check_val("p_rsp_done", rsp_done, 32'h1);
        check_val("p_rsp_bit", rsp_bit, 32'h1);
        check_val("p_owner_kept", owner, 32'h1);
        check_val("p_ready_back", req_ready, 32'h1);
        tick();
        check_val("p_done_1cyc", rsp_done, 32'h0);
        check_val("p_bit_hold", rsp_bit, 32'h1);
        req_valid = 2'b01; req_cmd = 4'b0011; push_ev(1'b0, 2'b01, 1'b0);
        tick();
        check_val("p_end_owner", owner, 32'h0);
        req_valid = 2'b00;

        // Timeout: r1 owns and stays silent, r0 waits with an end command.
        req_valid = 2'b10; req_cmd = 4'b0011;
        push_ev(1'b1, 2'b00, 1'b0);
        push_ev(1'b0, 2'b01, 1'b0);
        tick();
        check_val("t_grant", owner, 32'h2);
        req_valid = 2'b01;
        for (int k = 1; k < 8; k++) begin
            tick();
            check_val("t_no_tmo_yet", tmo, 32'h0);
            check_val("t_owner_hold", owner, 32'h2);
        end
        tick();
        check_val("t_tmo_pulse", tmo, 32'h1);
        check_val("t_owner_clear", owner, 32'h0);
        tick();
        check_val("t_pend_r0", owner, 32'h1);
        check_val("t_tmo_1cyc", tmo, 32'h0);
        tick();
        check_val("t_r0_end", owner, 32'h0);
        req_valid = 2'b00;

        // Accept exactly at counter = TMO-1 wins over the timeout.
        req_valid = 2'b01; req_cmd = 4'b0010; push_ev(1'b0, 2'b01, 1'b1);
        tick();
        check_val("e_grant", owner, 32'h1);
        req_valid = 2'b00;
        repeat (7) tick();
        check_val("e_pre_owner", owner, 32'h1);
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        check_val("e_no_tmo", tmo, 32'h0);
        check_val("e_eng_valid", eng_valid, 32'h1);
        check_val("e_eng_cmd", eng_cmd, 32'h2);
        check_val("e_owner", owner, 32'h1);
        eng_ready = 1'b1;
        tick();
        eng_ready = 1'b0;
        check_val("e_wait", eng_valid, 32'h0);
        eng_done = 1'b1; eng_bit = 1'b1;
        tick();
        eng_done = 1'b0; eng_bit = 1'b0;
        check_val("e_rsp_bit", rsp_bit, 32'h1);

        // Spurious eng_done in OWNED and in IDLE is ignored.
        eng_done = 1'b1; eng_bit = 1'b0;
        tick();
        eng_done = 1'b0;
        check_val("s_own_done", rsp_done, 32'h0);
        check_val("s_own_bit", rsp_bit, 32'h1);
        check_val("s_own_owner", owner, 32'h1);
        check_val("s_own_ready", req_ready, 32'h1);
        req_valid = 2'b01; req_cmd = 4'b0011; push_ev(1'b0, 2'b01, 1'b0);
        tick();
        check_val("s_end_owner", owner, 32'h0);
        req_valid = 2'b00;
        eng_done = 1'b1; eng_bit = 1'b1;
        tick();
        eng_done = 1'b0; eng_bit = 1'b0;
        check_val("s_idle_owner", owner, 32'h0);
        check_val("s_idle_bit", rsp_bit, 32'h0);
        check_val("s_idle_eng", eng_valid, 32'h0);

        // Reset in WAIT; a late eng_done has no effect.
        req_valid = 2'b10; req_cmd = 4'b0100;
        tick();
        check_val("w_grant", owner, 32'h2);
        tick();
        req_valid = 2'b00;
        check_val("w_eng_cmd", eng_cmd, 32'h1);
        eng_ready = 1'b1;
        tick();
        eng_ready = 1'b0;
        check_val("w_in_wait", eng_valid, 32'h0);
        reset_n = 1'b0;
        tick();
        check_rst("rst_wait");
        reset_n = 1'b1; eng_done = 1'b1; eng_bit = 1'b1;
        tick();
        eng_done = 1'b0; eng_bit = 1'b0;
        check_rst("rst_late_done");

        // Reset in ISSUE drops eng_valid at that edge.
        req_valid = 2'b01; req_cmd = 4'b0010;
        tick();
        tick();
        req_valid = 2'b00;
        check_val("i_eng_valid", eng_valid, 32'h1);
        reset_n = 1'b0;
        tick();
        check_rst("rst_issue");
        reset_n = 1'b1;

        // Tie-break restarts at r0 after reset.
        req_valid = 2'b11; req_cmd = 4'b1111; push_ev(1'b0, 2'b01, 1'b0);
        tick();
        check_val("r_tie_owner", owner, 32'h1);
        tick();
        req_valid = 2'b00; req_cmd = 4'b0000;
        check_val("r_end_owner", owner, 32'h0);

        repeat (3) tick();
        check_val("sb_drain", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
